// File: rtl/fetch_debug_display.sv
// fetch_debug_display
//   Debug front panel for the single-cycle datapath. A clock-enable sequencer
//   (HOLD / RUN / STEP / RUN-TO-BREAK) gates the fetch unit through FetchEn. A
//   multiplexed seven-segment display shows PC (low digits) and instruction
//   (high digits), with Page choosing the lower or upper half of each word.
//
// Ports
//   Clk        in   system clock
//   Reset      in   synchronous, active-high, clears every register
//   Mode       in   [1:0] 00 HOLD, 01 RUN, 10 STEP, 11 RUN_BREAK
//   Step       in   asynchronous push-button, one fetch per press in STEP
//   Page       in   0: show word bits [HALF*4-1:0]; 1: bits [31:32-HALF*4]
//   BreakAddr  in   [31:0] halt address for RUN_BREAK
//   PcIn       in   [31:0] current PC from the fetch unit
//   InstrIn    in   [31:0] current instruction from the fetch unit
//   FetchEn    out  one-cycle clock-enable pulse to the fetch unit / PC
//   Halted     out  high while stopped at the breakpoint
//   out7       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   en_out     out  [NUM_DIGITS-1:0] digit anodes, active-low, one-hot-low

module fetch_debug_display #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int SCAN_DIV   = 100_000,
   parameter int NUM_DIGITS = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [1:0]            Mode,
   input  logic                  Step,
   input  logic                  Page,
   input  logic [31:0]           BreakAddr,
   input  logic [31:0]           PcIn,
   input  logic [31:0]           InstrIn,
   output logic                  FetchEn,
   output logic                  Halted,
   output logic [6:0]            out7,
   output logic [NUM_DIGITS-1:0] en_out
);

   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int HALF = NUM_DIGITS / 2;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [IW-1:0] HALF_IDX  = IW'(HALF);
   localparam logic [5:0]    HI_BASE   = 6'(32 - HALF * 4);

   typedef enum logic [2:0] {
      S_HOLD,
      S_RUN,
      S_STEP,
      S_BRK,
      S_HALT
   } state_t;

   state_t          state, state_n, mode_st;
   logic [TW-1:0]   tick, tick_n;
   logic            fetch_n, halted_n;
   logic            s1, s2, s3, step_edge;

   logic [SW-1:0]   scan;
   logic [IW-1:0]   idx;
   logic [31:0]     word;
   logic [IW-1:0]   dig;
   logic [5:0]      bitpos;
   logic [3:0]      nib;
   logic [6:0]      seg_n;
   logic [NUM_DIGITS-1:0] en_n;

   function automatic state_t mode_state(input logic [1:0] m);
      case (m)
         2'b01:   return S_RUN;
         2'b10:   return S_STEP;
         2'b11:   return S_BRK;
         default: return S_HOLD;
      endcase
   endfunction

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Rising edge of the button after two synchroniser stages.
   assign step_edge = s2 & ~s3;

   // Sequencer next state. Any Mode change lands in the new mode's state with
   // the tick counter cleared; a pending step edge is dropped on leaving STEP.
   always_comb begin
      mode_st = mode_state(Mode);
      state_n = state;
      tick_n  = '0;
      fetch_n = 1'b0;
      case (state)
         S_HOLD: state_n = mode_st;
         S_RUN, S_BRK: begin
            if (mode_st != state) begin
               state_n = mode_st;
            end else if (tick == TICK_LAST) begin
               if (state == S_BRK && PcIn == BreakAddr)
                  state_n = S_HALT;
               else
                  fetch_n = 1'b1;
            end else begin
               tick_n = tick + 1'b1;
            end
         end
         S_STEP: begin
            if (mode_st != S_STEP)
               state_n = mode_st;
            else
               fetch_n = step_edge;
         end
         S_HALT: begin
            if (Mode != 2'b11)
               state_n = mode_st;
         end
         default: state_n = S_HOLD;
      endcase
      halted_n = (state_n == S_HALT);
   end

   // Digit content: low half of the digits shows PcIn, high half InstrIn,
   // each taken from the paged slice of the word.
   always_comb begin
      if (idx < HALF_IDX) begin
         word = PcIn;
         dig  = idx;
      end else begin
         word = InstrIn;
         dig  = idx - HALF_IDX;
      end
      bitpos = (Page ? HI_BASE : 6'd0) + 6'({dig, 2'b00});
      nib    = 4'(word >> bitpos);
      seg_n  = hex7(nib);
      en_n   = ~(NUM_DIGITS'(1) << idx);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= S_HOLD;
         tick    <= '0;
         s1      <= 1'b0;
         s2      <= 1'b0;
         s3      <= 1'b0;
         FetchEn <= 1'b0;
         Halted  <= 1'b0;
         scan    <= '0;
         idx     <= '0;
         out7    <= '1;
         en_out  <= '1;
      end else begin
         state   <= state_n;
         tick    <= tick_n;
         s1      <= Step;
         s2      <= s1;
         s3      <= s2;
         FetchEn <= fetch_n;
         Halted  <= halted_n;
         if (scan == SCAN_LAST) begin
            scan <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            scan <= scan + 1'b1;
         end
         // Segments and anode are registered together from the current idx so
         // the pair always changes on the same edge.
         out7   <= seg_n;
         en_out <= en_n;
      end
   end

endmodule

// File: tb/tb_fetch_debug_display.sv
// tb_fetch_debug_display
//   Directed bench for fetch_debug_display with TICK_DIV=4, SCAN_DIV=2,
//   NUM_DIGITS=8. Display patterns come from a vector table; sequencer
//   behaviour is exercised with hand-written cycle sequences.

module tb_fetch_debug_display;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [1:0]  Mode = 2'b00;
   logic        Step = 1'b0;
   logic        Page = 1'b0;
   logic [31:0] BreakAddr = '0;
   logic [31:0] PcIn = '0;
   logic [31:0] InstrIn = '0;
   logic        FetchEn;
   logic        Halted;
   logic [6:0]  out7;
   logic [7:0]  en_out;

   int n_cmp = 0;
   int n_err = 0;

   fetch_debug_display #(
      .TICK_DIV  (4),
      .SCAN_DIV  (2),
      .NUM_DIGITS(8)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Mode     (Mode),
      .Step     (Step),
      .Page     (Page),
      .BreakAddr(BreakAddr),
      .PcIn     (PcIn),
      .InstrIn  (InstrIn),
      .FetchEn  (FetchEn),
      .Halted   (Halted),
      .out7     (out7),
      .en_out   (en_out)
   );

   always #5 Clk = ~Clk;

   // Segment codes {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] H0 = 7'b1000000, H1 = 7'b1111001, H2 = 7'b0100100,
                          H3 = 7'b0110000, H4 = 7'b0011001, H5 = 7'b0010010,
                          H6 = 7'b0000010, H7 = 7'b1111000, H8 = 7'b0000000,
                          H9 = 7'b0010000, HA = 7'b0001000, HB = 7'b0000011,
                          HC = 7'b1000110, HD = 7'b0100001, HE = 7'b0000110,
                          HF = 7'b0001110;

   typedef struct {
      logic        page;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [6:0]  seg [8];
   } scan_vec_t;

   scan_vec_t vecs [4];

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      // ---------------- display vector table ----------------
      vecs[0].page = 1'b0; vecs[0].pc = 32'h0000_1234; vecs[0].instr = 32'hDEAD_ABCD;
      vecs[0].seg = '{H4, H3, H2, H1, HD, HC, HB, HA};
      vecs[1].page = 1'b1; vecs[1].pc = 32'h0000_1234; vecs[1].instr = 32'hDEAD_ABCD;
      vecs[1].seg = '{H0, H0, H0, H0, HD, HA, HE, HD};
      vecs[2].page = 1'b0; vecs[2].pc = 32'h7654_3210; vecs[2].instr = 32'hFEDC_9876;
      vecs[2].seg = '{H0, H1, H2, H3, H6, H7, H8, H9};
      vecs[3].page = 1'b1; vecs[3].pc = 32'h7654_3210; vecs[3].instr = 32'hFEDC_9876;
      vecs[3].seg = '{H4, H5, H6, H7, HC, HD, HE, HF};

      // ---------------- reset with Mode=RUN requested ----------------
      Mode  = 2'b01;
      Reset = 1'b1;
      Step  = 1'b1;
      repeat (3) cyc();
      chk("rst_fetch",  32'(FetchEn), 32'd0);
      chk("rst_halted", 32'(Halted),  32'd0);
      chk("rst_out7",   32'(out7),    32'h7F);
      chk("rst_en",     32'(en_out),  32'hFF);
      Step  = 1'b0;
      Reset = 1'b0;
      cyc();                                   // HOLD -> RUN on this edge
      chk("post_rst_fetch",  32'(FetchEn), 32'd0);
      chk("post_rst_halted", 32'(Halted),  32'd0);

      // ---------------- RUN: pulse every 4 cycles ----------------
      for (int c = 1; c <= 16; c++) begin
         cyc();
         chk($sformatf("run_c%0d", c), 32'(FetchEn), 32'((c % 4) == 0));
      end

      // ---------------- STEP: held button gives one pulse ----------------
      Mode = 2'b10;
      cyc();
      chk("step_entry", 32'(FetchEn), 32'd0);
      for (int press = 0; press < 2; press++) begin
         Step = 1'b1;
         for (int j = 1; j <= 20; j++) begin
            cyc();
            chk($sformatf("step%0d_j%0d", press, j), 32'(FetchEn), 32'(j == 3));
         end
         Step = 1'b0;
         for (int j = 1; j <= 5; j++) begin
            cyc();
            chk($sformatf("step%0d_rel%0d", press, j), 32'(FetchEn), 32'd0);
         end
      end

      // ---------------- RUN_BREAK: halt at PC=8 ----------------
      begin
         logic [31:0] pc_model;
         int          pulses;
         pc_model  = 32'd0;
         pulses    = 0;
         PcIn      = pc_model;
         BreakAddr = 32'h0000_0008;
         Mode      = 2'b11;
         cyc();                                // STEP -> BRK, tick cleared
         for (int c = 1; c <= 20; c++) begin
            cyc();
            chk($sformatf("brk_fetch_c%0d", c), 32'(FetchEn), 32'(c == 4 || c == 8));
            chk($sformatf("brk_halt_c%0d", c),  32'(Halted),  32'(c >= 12));
            if (FetchEn) begin
               pulses++;
               pc_model = pc_model + 32'd4;
               PcIn     = pc_model;
            end
         end
         chk("brk_pulses", 32'(pulses), 32'd2);
         chk("brk_pc",     pc_model,    32'd8);
      end
      Mode = 2'b00;
      cyc();
      chk("unhalt_halted", 32'(Halted), 32'd0);
      for (int c = 1; c <= 6; c++) begin
         cyc();
         chk($sformatf("hold_fetch_c%0d", c), 32'(FetchEn), 32'd0);
      end

      // ---------------- display scan, table-driven ----------------
      for (int v = 0; v < 4; v++) begin
         Reset   = 1'b1;
         Mode    = 2'b00;
         cyc();
         Page    = vecs[v].page;
         PcIn    = vecs[v].pc;
         InstrIn = vecs[v].instr;
         Reset   = 1'b0;
         for (int k = 0; k < 16; k++) begin
            logic [7:0] exp_en;
            cyc();
            exp_en = ~(8'd1 << (k / 2));
            chk($sformatf("scan%0d_en_k%0d", v, k),  32'(en_out), 32'(exp_en));
            chk($sformatf("scan%0d_seg_k%0d", v, k), 32'(out7),   32'(vecs[v].seg[k/2]));
         end
      end

      // ---------------- reset mid-RUN and mid-scan ----------------
      Page    = 1'b0;
      PcIn    = 32'h0000_1234;
      InstrIn = 32'hDEAD_ABCD;
      Mode    = 2'b00;
      repeat (5) cyc();                        // scan has left digit 0
      Mode = 2'b01;
      cyc();                                   // enter RUN
      repeat (2) cyc();
      Reset = 1'b1;
      cyc();                                   // would be tick 3 edge
      chk("midrst_fetch", 32'(FetchEn), 32'd0);
      chk("midrst_en",    32'(en_out),  32'hFF);
      chk("midrst_out7",  32'(out7),    32'h7F);
      cyc();                                   // terminal-count edge held in reset
      chk("midrst_fetch2", 32'(FetchEn), 32'd0);
      Reset = 1'b0;
      cyc();                                   // HOLD -> RUN
      chk("rel_en",   32'(en_out),  32'hFE);
      chk("rel_out7", 32'(out7),    32'(H4));
      chk("rel_fetch", 32'(FetchEn), 32'd0);
      for (int c = 1; c <= 4; c++) begin
         cyc();
         chk($sformatf("rel_run_c%0d", c), 32'(FetchEn), 32'(c == 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
